// File: rtl/reg_file_wb_if.sv
// rtl/reg_file_wb_if.sv - bus interface for the write-back register file
interface reg_file_wb_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          WE;
  logic [AW-1:0] WA;
  logic [DW-1:0] WD;
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
  logic [DW-1:0] OA;
  logic [DW-1:0] OB;
  logic [AW-1:0] DA;
  logic [DW-1:0] DO;
  logic          PEND;

  modport master (
    output WE, WA, WD, RA, RB, DA,
    input  OA, OB, DO, PEND
  );

  modport slave (
    input  WE, WA, WD, RA, RB, DA,
    output OA, OB, DO, PEND
  );
endinterface

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - register file with one-entry write-back stage and read forwarding
module reg_file_wb #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  reg_file_wb_if.slave  bus
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] mem_q [NREG];
  logic          pv_q, pv_d;
  logic [AW-1:0] pa_q, pa_d;
  logic [DW-1:0] pd_q, pd_d;

  // Next pending entry: capture a write unless it targets r0, else go idle
  always_comb begin
    pv_d = 1'b0;
    pa_d = pa_q;
    pd_d = pd_q;
    if (bus.WE && (bus.WA != '0)) begin
      pv_d = 1'b1;
      pa_d = bus.WA;
      pd_d = bus.WD;
    end
  end

  // Write-back stage register; reset discards an uncommitted write
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pv_q <= 1'b0;
      pa_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q <= pv_d;
      pa_q <= pa_d;
      pd_q <= pd_d;
    end
  end

  // Array update: clear on reset, otherwise commit the entry pending before this edge
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (pv_q) begin
      mem_q[pa_q] <= pd_q;
    end
  end

  // Read ports: r0 reads zero, pending entry is forwarded, otherwise array contents
  assign bus.OA = (bus.RA == '0)                 ? '0   :
                  (pv_q && (pa_q == bus.RA))     ? pd_q :
                                                   mem_q[bus.RA];
  assign bus.OB = (bus.RB == '0)                 ? '0   :
                  (pv_q && (pa_q == bus.RB))     ? pd_q :
                                                   mem_q[bus.RB];

  // Debug port sees committed contents only
  assign bus.DO   = (bus.DA == '0) ? '0 : mem_q[bus.DA];
  assign bus.PEND = pv_q;
endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - randomized and directed self-checking bench for reg_file_wb
module tb_reg_file_wb;
  logic CLK;
  logic Reset;

  reg_file_wb_if #(.DW(16), .AW(4)) bus ();

  reg_file_wb #(.DW(16), .AW(4)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  // Reference: committed register contents plus a queue of writes not yet committed
  logic [15:0] arr [16];
  wr_t         pq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0000;
    if (pq.size() != 0 && pq[pq.size()-1].a == idx) return pq[pq.size()-1].d;
    return arr[idx];
  endfunction

  function automatic logic [15:0] model_dbg(input logic [3:0] idx);
    if (idx == 4'd0) return 16'h0000;
    return arr[idx];
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, clock, advance model
  task automatic step(input logic rst, input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] da, input bit chk);
    @(negedge CLK);
    Reset  = rst;
    bus.WE = we;
    bus.WA = wa;
    bus.WD = wd;
    bus.RA = ra;
    bus.RB = rb;
    bus.DA = da;
    #1;
    if (chk) begin
      check("OA", {16'h0, bus.OA}, {16'h0, model_rd(ra)});
      check("OB", {16'h0, bus.OB}, {16'h0, model_rd(rb)});
      check("DO", {16'h0, bus.DO}, {16'h0, model_dbg(da)});
      check("PEND", {31'h0, bus.PEND}, {31'h0, (pq.size() != 0)});
    end
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 16; i++) arr[i] = 16'h0000;
      pq.delete();
    end else begin
      while (pq.size() != 0) begin
        arr[pq[0].a] = pq[0].d;
        void'(pq.pop_front());
      end
      if (we && wa != 4'd0) pq.push_back('{a: wa, d: wd});
    end
  endtask

  task automatic wr(input logic [3:0] wa, input logic [15:0] wd);
    step(1'b0, 1'b1, wa, wd, wa, wa, wa, 1'b1);
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 4'd3, 1'b1);
  endtask

  // Set read indices between edges and wait for the combinational outputs to settle
  task automatic peek(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] da);
    bus.RA = ra;
    bus.RB = rb;
    bus.DA = da;
    #2;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    bus.WE = 1'b0;
    bus.WA = '0;
    bus.WD = '0;
    bus.RA = '0;
    bus.RB = '0;
    bus.DA = '0;
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 4'd0, 1'b1);

    // T1: fill every register, then a single reset edge clears everything
    for (int i = 1; i < 16; i++) wr(4'(i), 16'($urandom));
    step(1'b1, 1'b1, 4'd4, 16'hAAAA, 4'd1, 4'd2, 4'd3, 1'b1);
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), 4'(15 - i), 4'(i));
      check("t1_oa", {16'h0, bus.OA}, 32'h0);
      check("t1_ob", {16'h0, bus.OB}, 32'h0);
      check("t1_do", {16'h0, bus.DO}, 32'h0);
    end
    check("t1_pend", {31'h0, bus.PEND}, 32'h0);

    // T2: forwarding in N+1, committed in N+2
    wr(4'd3, 16'hBEEF);
    peek(4'd3, 4'd3, 4'd3);
    check("t2_oa_fwd", {16'h0, bus.OA}, 32'hBEEF);
    check("t2_pend", {31'h0, bus.PEND}, 32'h1);
    check("t2_do_old", {16'h0, bus.DO}, 32'h0);
    nop();
    peek(4'd3, 4'd3, 4'd3);
    check("t2_do_new", {16'h0, bus.DO}, 32'hBEEF);
    check("t2_pend_clr", {31'h0, bus.PEND}, 32'h0);

    // T3: writes to r0 are ignored
    wr(4'd0, 16'hFFFF);
    peek(4'd0, 4'd0, 4'd0);
    check("t3_pend", {31'h0, bus.PEND}, 32'h0);
    check("t3_oa", {16'h0, bus.OA}, 32'h0);
    nop();
    peek(4'd0, 4'd0, 4'd0);
    check("t3_oa2", {16'h0, bus.OA}, 32'h0);

    // T4: same-index back-to-back writes
    wr(4'd5, 16'h1111);
    peek(4'd1, 4'd5, 4'd5);
    check("t4_ob1", {16'h0, bus.OB}, 32'h1111);
    wr(4'd5, 16'h2222);
    peek(4'd1, 4'd5, 4'd5);
    check("t4_ob2", {16'h0, bus.OB}, 32'h2222);
    check("t4_do_mid", {16'h0, bus.DO}, 32'h1111);
    nop();
    peek(4'd1, 4'd5, 4'd5);
    check("t4_do_final", {16'h0, bus.DO}, 32'h2222);

    // T5: reset immediately after a write discards it
    wr(4'd7, 16'h1234);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd7, 4'd7, 4'd7, 1'b1);
    peek(4'd7, 4'd7, 4'd7);
    check("t5_do", {16'h0, bus.DO}, 32'h0);
    check("t5_oa", {16'h0, bus.OA}, 32'h0);
    check("t5_pend", {31'h0, bus.PEND}, 32'h0);

    // T6: dual read of different-index back-to-back writes
    wr(4'd2, 16'h00AA);
    wr(4'd9, 16'h5500);
    nop();
    peek(4'd2, 4'd9, 4'd2);
    check("t6_oa", {16'h0, bus.OA}, 32'h00AA);
    check("t6_ob", {16'h0, bus.OB}, 32'h5500);
    check("t6_do", {16'h0, bus.DO}, 32'h00AA);
    peek(4'd9, 4'd9, 4'd9);
    check("t6_oa_same", {16'h0, bus.OA}, 32'h5500);
    check("t6_ob_same", {16'h0, bus.OB}, 32'h5500);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      logic       rst, we;
      logic [3:0] wa, ra, rb, da;
      rst = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 1);
      wa  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? wa : 4'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? ra : 4'($urandom_range(0, 3));
      da  = 4'($urandom);
      step(rst, we, wa, 16'($urandom), ra, rb, da, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
